// File: rtl/ps_pkg.sv
// Shared program-sequencer definitions: STKY bit positions, ureg addresses
// and the PC stack request decode.
package ps_pkg;

    localparam int unsigned STKY_W     = 4;
    localparam int unsigned STKY_EMPTY = 0;
    localparam int unsigned STKY_FULL  = 1;
    localparam int unsigned STKY_OVF   = 2;
    localparam int unsigned STKY_UNF   = 3;

    localparam logic [4:0] UREG_PCSTCK = 5'b00100;
    localparam logic [4:0] UREG_PCSTKP = 5'b00101;
    localparam logic [4:0] UREG_STKY   = 5'b11110;

    typedef enum logic [2:0] {
        STK_OP_NONE = 3'd0,
        STK_OP_PUSH = 3'd1,
        STK_OP_POP  = 3'd2,
        STK_OP_REPL = 3'd3,
        STK_OP_WR   = 3'd4
    } stk_op_e;

    // Push/pop take priority over a ureg write; push+pop collapses to replace-top.
    function automatic stk_op_e stk_decode(input logic push_req,
                                           input logic pop_req,
                                           input logic wr_req);
        stk_op_e op;
        op = STK_OP_NONE;
        if (push_req && pop_req) begin
            op = STK_OP_REPL;
        end else if (push_req) begin
            op = STK_OP_PUSH;
        end else if (pop_req) begin
            op = STK_OP_POP;
        end else if (wr_req) begin
            op = STK_OP_WR;
        end
        return op;
    endfunction

endpackage

// File: rtl/ps_stck_mem.sv
// PC stack storage: DEPTH x AW registers, one synchronous write port,
// one asynchronous read port, cleared on reset.
module ps_stck_mem
    import ps_pkg::*;
#(
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTRW  = 4
) (
    input  logic            clk_rf,
    input  logic            rst,
    input  logic            i_we,
    input  logic [PTRW-1:0] i_waddr,
    input  logic [AW-1:0]   i_wdata,
    input  logic [PTRW-1:0] i_raddr,
    output logic [AW-1:0]   o_rdata
);

    logic [AW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_rf or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i_waddr == PTRW'(i)) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Compare-select read keeps out-of-range addresses at zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i_raddr == PTRW'(i)) begin
                o_rdata = r_mem[i];
            end
        end
    end

endmodule

// File: rtl/ps_pcstck_unit.sv
// Program-sequencer PC stack: DEPTH-entry LIFO serving CALL/RTRN, PUSH/POP
// PCSTK and PCSTCK ureg writes, with sticky overflow/underflow status.
module ps_pcstck_unit
    import ps_pkg::*;
#(
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTRW  = 4
) (
    input  logic              clk_rf,
    input  logic              rst,
    input  logic              stallb,
    input  logic              ps_call,
    input  logic              ps_pshstck,
    input  logic              ps_rtrn,
    input  logic              ps_popstck,
    input  logic [AW-1:0]     call_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_dt,
    input  logic              clr_stcky,
    output logic [AW-1:0]     ps_pcstck,
    output logic [PTRW-1:0]   ps_pcstck_pntr,
    output logic [STKY_W-1:0] ps_stcky,
    output logic              ps_ovf_halt
);

    logic [PTRW-1:0] r_ptr;
    logic            r_ovf;
    logic            r_unf;

    logic            w_push_req;
    logic            w_pop_req;
    logic [AW-1:0]   w_push_data;
    logic            w_empty;
    logic            w_full;
    logic [PTRW-1:0] w_top_idx;
    stk_op_e         w_op;

    logic            w_we;
    logic [PTRW-1:0] w_waddr;
    logic [AW-1:0]   w_wdata;
    logic [PTRW-1:0] w_ptr_nxt;
    logic            w_ovf_set;
    logic            w_unf_set;
    logic            w_ovf_nxt;
    logic            w_unf_nxt;
    logic [AW-1:0]   w_rdata;

    assign w_push_req  = ps_call | ps_pshstck;
    assign w_pop_req   = ps_rtrn | ps_popstck;
    assign w_push_data = ps_call ? call_addr : wr_dt;
    assign w_empty     = (r_ptr == '0);
    assign w_full      = (r_ptr == PTRW'(DEPTH));
    assign w_top_idx   = r_ptr - PTRW'(1);
    assign w_op        = stallb ? stk_decode(w_push_req, w_pop_req, wr_en) : STK_OP_NONE;

    // Pointer, write-port and sticky-set decisions for the sampled request.
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = w_top_idx;
        w_wdata   = w_push_data;
        w_ptr_nxt = r_ptr;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (w_op)
            STK_OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we      = 1'b1;
                    w_waddr   = r_ptr;
                    w_ptr_nxt = r_ptr + PTRW'(1);
                end
            end
            STK_OP_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_ptr_nxt = w_top_idx;
                end
            end
            STK_OP_REPL: begin
                // Empty: the pop has nothing to take, so only the push lands.
                w_we = 1'b1;
                if (w_empty) begin
                    w_waddr   = '0;
                    w_ptr_nxt = PTRW'(1);
                    w_unf_set = 1'b1;
                end
            end
            STK_OP_WR: begin
                w_we    = ~w_empty;
                w_wdata = wr_dt;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Set beats a coincident clear; a stall freezes the clear as well.
    always_comb begin
        w_ovf_nxt = r_ovf;
        w_unf_nxt = r_unf;
        if (stallb) begin
            w_ovf_nxt = w_ovf_set | (r_ovf & ~clr_stcky);
            w_unf_nxt = w_unf_set | (r_unf & ~clr_stcky);
        end
    end

    always_ff @(posedge clk_rf or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

    ps_stck_mem #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_stck_mem (
        .clk_rf  (clk_rf),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_top_idx),
        .o_rdata (w_rdata)
    );

    assign ps_pcstck      = w_empty ? '0 : w_rdata;
    assign ps_pcstck_pntr = r_ptr;
    assign ps_ovf_halt    = r_ovf;

    always_comb begin
        ps_stcky             = '0;
        ps_stcky[STKY_EMPTY] = w_empty;
        ps_stcky[STKY_FULL]  = w_full;
        ps_stcky[STKY_OVF]   = r_ovf;
        ps_stcky[STKY_UNF]   = r_unf;
    end

endmodule

// File: doc/ps_pcstck_unit.md
Name: ps_pcstck_unit

Overview:
- Parametrised program-sequencer PC stack. Replaces the single-entry PC stack register and 1-bit pointer with a DEPTH-entry LIFO.
- Serves CALL/RTRN, PUSH/POP PCSTK and ureg writes of PCSTCK.
- Reports {underflow, overflow, full, empty} sticky status. The overflow sticky is used by the sequencer to halt fetch.
- Sits in the clk_rf domain beside ASTAT/MODE1.

Parameters:
- AW, 16, width of a stack entry (PC address width)
- DEPTH, 8, number of stack entries (≥2)
- PTRW, 4, pointer width; must satisfy 2^PTRW > DEPTH

Ports:
- clk_rf  in  1  register-file phase clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- stallb  in  1  0 = stall: all inputs ignored, all state held
- ps_call  in  1  push call_addr (CALL taken)
- ps_pshstck  in  1  push wr_dt (PUSH PCSTK)
- ps_rtrn  in  1  pop (RTRN taken)
- ps_popstck  in  1  pop (POP PCSTK)
- call_addr  in  AW  return address pushed on call
- wr_en  in  1  ureg write to PCSTCK (overwrite top entry)
- wr_dt  in  AW  ureg/bus data for wr_en and ps_pshstck
- clr_stcky  in  1  ureg write to STKY: clears the overflow and underflow stickies
- ps_pcstck  out  AW  top-of-stack entry; 0 when empty
- ps_pcstck_pntr  out  PTRW  number of valid entries, 0..DEPTH
- ps_stcky  out  4  {underflow, overflow, full, empty}
- ps_ovf_halt  out  1  equals the overflow sticky

Behaviour:
Reset (rst low, asynchronous):
- pointer = 0; entries cleared to 0; overflow and underflow stickies = 0.
- Outputs: ps_pcstck = 0, ps_pcstck_pntr = 0, ps_stcky = 4'b0001, ps_ovf_halt = 0.

Timing:
- All outputs are combinational from registers only (no input-to-output paths).
- An operation sampled at posedge N is visible on the outputs after posedge N.
- empty = (ptr == 0); full = (ptr == DEPTH). These are derived, not stored.

Request decode:
- push_req = ps_call | ps_pshstck. If both are high, ps_call wins and only one entry is pushed (call_addr).
- pop_req = ps_rtrn | ps_popstck. Coincident pops count as one pop.

Operations (stallb = 1):
- push only, not full: mem[ptr] = push data; ptr + 1.
- push only, full: no write, ptr held, overflow sticky set.
- pop only, not empty: ptr − 1; entry contents left unchanged.
- pop only, empty: ptr held, underflow sticky set.
- push and pop, not empty (full included): top entry mem[ptr−1] is replaced with push data; ptr held; no flag.
- push and pop, empty: push performed (ptr = 1), underflow sticky set.
- wr_en, no push/pop, not empty: mem[ptr−1] = wr_dt.
- wr_en, empty: ignored, no flag.
- wr_en with push or pop: wr_en ignored; the push/pop takes priority.

Stickies:
- Overflow and underflow are sticky until clr_stcky or reset.
- If a set and clr_stcky occur in the same cycle, set wins.
- clr_stcky does not affect pointer or entries.

Halt and stall:
- ps_ovf_halt stays high until clr_stcky. While it is high, push requests are still evaluated (stack remains full).
- stallb = 0: nothing changes, including sticky clear.

Arithmetic:
- Pointer never wraps: saturates at 0 and DEPTH.
- Entry index = ptr − 1, computed in PTRW bits, used only when ptr ≠ 0.

Decomposition:
- Shared package ps_pkg holds:
  - STKY bit indices: EMPTY = 0, FULL = 1, OVF = 2, UNF = 3.
  - Ureg addresses: PCSTCK = 5'b00100, PCSTKP = 5'b00101, STKY = 5'b11110.
- Sub-module ps_stck_mem: DEPTH×AW register array with one synchronous write port, one asynchronous read port and async reset.
- Pointer, request priority and flag logic stay in ps_pcstck_unit.

Test Plan:
- Reset, then 3 calls with call_addr = 16'h0010/0011/0012 → ptr = 3, ps_pcstck = 16'h0012, ps_stcky = 4'b0000; 3 rtrn → ps_pcstck goes 0011, 0010, 0; ptr = 0; ps_stcky = 4'b0001.
- 8 pushes (DEPTH = 8), then a 9th call → ptr = 8, ps_stcky = 4'b0110, ps_ovf_halt = 1, top unchanged; clr_stcky → ps_stcky = 4'b0010, ps_ovf_halt = 0.
- Empty stack, ps_rtrn → ptr = 0, ps_stcky = 4'b1001; same-cycle ps_call (16'h0055) + ps_rtrn on empty → ptr = 1, top = 16'h0055, underflow set.
- ptr = 2 with top 16'h0020: push+pop with wr_dt = 16'hABCD → ptr = 2, top = 16'hABCD; wr_en with 16'h1234 → top = 16'h1234; wr_en together with pop → ptr = 1, no write.
- stallb = 0 held over a call, a pop and clr_stcky → no state change. Assert rst mid-sequence (ptr = 5, overflow set) → immediately ptr = 0, ps_stcky = 4'b0001, ps_pcstck = 0.
